muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide controller for the EX stage. It sits beside the single-cycle integer ALU and owns a private shift-add/restoring-subtract datapath.
- It accepts one M-extension operation per start and holds the pipeline via stall while iterating. It returns a 32-bit result with a one-cycle done pulse.
- Operands are the same rs1/rs2 values that feed the ALU. The op select is instruction funct3.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must be able to hold XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock, synchronous, active-high
- start  input  1  level; EX holds a valid M-op (opcode 0110011, funct7 0000001)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  32  operand A (multiplicand / dividend)
- rs2  input  32  operand B (multiplier / divisor)
- flush  input  1  synchronous abort (branch/jump flush of EX)
- stall  output  1  combinational; freezes IF/ID/EX while the op is in flight
- busy  output  1  registered; state is RUN or SIGN
- done  output  1  registered; one-cycle pulse when result is valid
- result  output  32  registered; holds the last completed value

Behaviour:
- States: IDLE, RUN, SIGN, DONE. Priority at every edge: rst > flush > FSM.
- Reset values: state=IDLE, count=0, done=0, busy=0, result=0.
- IDLE, start=1: latch funct3 and operand signs.
  - Convert to magnitudes: MULH/DIV/REM use both operands signed; MULHSU uses rs1 signed only; others are unsigned.
  - Clear the 64-bit accumulator, count=0, go to RUN.
- RUN: one bit per cycle. count increments; at count==XLEN-1 go to SIGN.
  - Multiply: if multiplier LSB is set, upper half += multiplicand; then shift {acc} right by 1 (33-bit add keeps the carry).
  - Divide: shift {rem,quot} left by 1; trial-subtract the divisor magnitude from the 33-bit remainder; if non-negative, commit and set the quotient LSB.
- SIGN (1 cycle): produce the final value.
  - Product: two's-complement negate the 64-bit product if the operand signs differ. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
  - Quotient: negated if the signs differ. Remainder: takes the dividend's sign.
  - Divisor==0 overrides: quotient=32'hFFFFFFFF, remainder=rs1 as latched.
  - Signed overflow (DIV/REM, rs1=32'h80000000, rs2=32'hFFFFFFFF) overrides: quotient=32'h80000000, remainder=0.
  - Write result, done<=1, go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE. start is ignored in DONE; the same instruction leaves EX this cycle.
- stall = (state==IDLE & start) | (state==RUN) | (state==SIGN). It is 0 in DONE so the pipeline advances with result valid.
- Latency (no early-out): start sampled at edge E0 → RUN for edges E1..E32 → SIGN at E33 → done high in the cycle after E33 (34 cycles of stall).
- Back-to-back: a new start is accepted in the IDLE cycle immediately after DONE.
- flush in any state: next state IDLE, busy=0, done stays 0, result unchanged. An aborted op never pulses done.
- start in IDLE with flush=1 in the same cycle is not accepted.
- Operands are latched only in IDLE; rs1/rs2 changes during RUN have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, with start=1, these cases skip RUN and go straight to SIGN:
  - divisor==0
  - DIV/REM signed-overflow pattern
  - multiply with either operand==0
- Skipped ops produce done one cycle after acceptance + 1, i.e. a 2-cycle stall; all results are identical to the full path.
- Not defined: every op takes the full 34-cycle path; no comparators on the operands in IDLE.

Test Plan:
- MUL rs1=7, rs2=-3 (32'hFFFFFFFD) → after 34 cycles: done=1 for exactly 1 cycle, result=32'hFFFFFFEB; stall low in the done cycle.
- MULHU rs1=32'hFFFFFFFF, rs2=32'hFFFFFFFF → result=32'hFFFFFFFE. MULHSU rs1=-1, rs2=32'hFFFFFFFF → result=32'hFFFFFFFF.
- DIV rs1=-7, rs2=2 → result=32'hFFFFFFFD (-3). REM with the same operands → 32'hFFFFFFFF (-1). REMU rs1=100, rs2=7 → 2.
- Divide by zero: DIVU rs1=123, rs2=0 → 32'hFFFFFFFF. REM rs1=-5, rs2=0 → 32'hFFFFFFFB. DIV 32'h80000000 / -1 → 32'h80000000; REM of the same → 0. With MULDIV_EARLY_OUT_EN, each completes with a 2-cycle stall.
- Abort and reset: flush at cycle 10 of RUN → IDLE next cycle, no done pulse, result keeps its prior value. rst mid-RUN → all outputs 0 next edge. A new DIVU 9/3 afterwards → 3.
- Back-to-back: MUL then DIVU with start held continuously → two separate done pulses 35 cycles apart, correct results for each.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN lets trivial ops (x*0, /0, signed overflow) bypass iteration.
//
// state | meaning
// IDLE  | waiting for start; operands latched and converted to magnitudes on accept
// RUN   | one multiply/divide bit per cycle, XLEN cycles
// SIGN  | sign fix-up and special-case overrides, result written
// DONE  | one-cycle done pulse, pipeline advances
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_t state, state_nxt;

  logic [2:0]        op;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  count;

  // operand conversion at accept
  logic            signed_a, signed_b, sa, sb, early;
  logic [XLEN-1:0] rs1_mag, rs2_mag;

  assign signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
  assign signed_b = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
  assign sa       = signed_a && rs1[XLEN-1];
  assign sb       = signed_b && rs2[XLEN-1];
  assign rs1_mag  = sa ? -rs1 : rs1;
  assign rs2_mag  = sb ? -rs2 : rs2;

`ifdef MULDIV_EARLY_OUT_EN
  logic ovf_in;
  assign ovf_in = funct3[2] && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
  assign early  = funct3[2] ? ((rs2 == '0) || ovf_in) : ((rs1 == '0) || (rs2 == '0));
`else
  assign early  = 1'b0;
`endif

  // one iteration step of each algorithm
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? a_mag : '0)};
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_trial = div_shift - {1'b0, b_mag};
  assign div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  // final value formed in SIGN
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, final_res;
  logic              div_zero, div_ovf;

  assign div_zero = (b_mag == '0);
  assign div_ovf  = !op[0] && neg_a && neg_b && (a_mag == MIN_NEG) && (b_mag == XLEN'(1));
  assign prod     = (neg_a ^ neg_b) ? -acc : acc;

  always_comb begin
    quot = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (div_zero) begin
      quot = '1;
      rem  = neg_a ? -a_mag : a_mag;
    end else if (div_ovf) begin
      quot = MIN_NEG;
      rem  = '0;
    end
    if (op[2])
      final_res = op[1] ? rem : quot;
    else
      final_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = early ? SIGN : RUN;
      RUN:     if (count == LAST) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign stall = ((state == IDLE) && start) || (state == RUN) || (state == SIGN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      op     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == SIGN);
      done  <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: if (start) begin
            op    <= funct3;
            neg_a <= sa;
            neg_b <= sb;
            a_mag <= rs1_mag;
            b_mag <= rs2_mag;
            count <= '0;
            // divide keeps the dividend in the low half; multiply keeps the multiplier there
            if (early)
              acc <= '0;
            else
              acc <= {{XLEN{1'b0}}, (funct3[2] ? rs1_mag : rs2_mag)};
          end
          RUN: begin
            acc   <= op[2] ? div_next : mul_next;
            count <= count + CNT_W'(1);
          end
          SIGN: begin
            result <= final_res;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
